muldiv_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths, mul/div op codes, and
// state encodings for the iterative mul/div unit.
package cpu_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_MULL = 2'b00,
    OP_MULH = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WB   = 2'b10
  } md_state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: WIDTH iterations, then
// a one-cycle register-file write-back.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH  = cpu_pkg::WIDTH,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [ADDR_W-1:0] addrR,
  output logic [WIDTH-1:0]  dataR,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] result;
  logic             b_zero;

  // hi:lo holds the product (mul) or remainder:quotient (div)
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = div_sh >= {1'b0, b_q};
    div_hi   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], div_ge};
    step_hi  = is_div(op_q) ? div_hi : mul_hi;
    step_lo  = is_div(op_q) ? div_lo : mul_lo;
    b_zero   = (b_q == '0);
    result   = '0;
    unique case (op_q)
      OP_MULL: result = step_lo;
      OP_MULH: result = step_hi;
      OP_DIVU: result = b_zero ? '1 : step_lo;
      OP_REMU: result = b_zero ? a_q : step_hi;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    dbz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          a_d     = opA;
          b_d     = opB;
          dest_d  = dest;
          hi_d    = '0;
          lo_d    = is_div(op_e'(op)) ? opA : opB;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_WB;
          we_d    = 1'b1;
          addr_d  = dest_q;
          data_d  = result;
          dbz_d   = is_div(op_q) && b_zero;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULL;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = we_q;
  assign we          = we_q;
  assign addrR       = addr_q;
  assign dataR       = data_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic
// reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opA, opB;
  logic [2:0]  dest;
  logic        busy, done, we, div_by_zero;
  logic [2:0]  addrR;
  logic [15:0] dataR;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .opA(opA), .opB(opB), .dest(dest), .busy(busy),
    .done(done), .we(we), .addrR(addrR), .dataR(dataR),
    .div_by_zero(div_by_zero)
  );

  function automatic logic [15:0] model(input logic [1:0] o,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      2'd0: return p[15:0];
      2'd1: return p[31:16];
      2'd2: return (b == 0) ? 16'hFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Observation record of one operation
  logic [15:0] r_data;
  logic [2:0]  r_addr;
  logic        r_dbz, r_done_ok;
  int          r_lat, r_we_cnt, r_busy_len, r_spurious;

  task automatic run_op(input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] d,
                        input int poke_at);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b; dest = d;
    r_lat = -1; r_we_cnt = 0; r_busy_len = 0; r_spurious = 0;
    r_data = '0; r_addr = '0; r_dbz = 1'b0; r_done_ok = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (busy) r_busy_len++;
      if (done !== we) r_done_ok = 1'b0;
      if (we) begin
        r_we_cnt++;
        if (r_lat < 0) begin
          r_lat = i; r_data = dataR; r_addr = addrR; r_dbz = div_by_zero;
        end
      end else if (dataR !== 0 || addrR !== 0 || div_by_zero !== 0) begin
        r_spurious++;
      end
      start = (i == poke_at);
      op = 2'($urandom); opA = 16'($urandom); opB = 16'($urandom);
      dest = 3'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 0; opA = 0; opB = 0; dest = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, we, div_by_zero, addrR, dataR} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b we=%b addr=%0d data=%h, need all 0",
               busy, we, addrR, dataR);
    end
    reset = 1'b0;
  endtask

  task automatic test_mull_basic();
    run_op(2'd0, 16'h1234, 16'h0010, 3'd3, 0);
    checks++;
    if (r_data !== 16'h2340 || r_addr !== 3'd3 || r_dbz !== 1'b0) begin
      errors++;
      $display("FAIL mull_basic: got data=%h addr=%0d dbz=%b, need 2340 3 0",
               r_data, r_addr, r_dbz);
    end
    checks++;
    if (r_lat != 17 || r_we_cnt != 1) begin
      errors++;
      $display("FAIL mull_timing: got lat=%0d we_pulses=%0d, need 17 1",
               r_lat, r_we_cnt);
    end
    checks++;
    if (r_spurious != 0 || !r_done_ok) begin
      errors++;
      $display("FAIL idle_outputs: got spurious=%0d done_ok=%b, need 0 1",
               r_spurious, r_done_ok);
    end
  endtask

  task automatic test_mul_max();
    run_op(2'd1, 16'hFFFF, 16'hFFFF, 3'd5, 0);
    checks++;
    if (r_data !== 16'hFFFE || r_addr !== 3'd5) begin
      errors++;
      $display("FAIL mulh_max: got %h addr %0d, need fffe 5", r_data, r_addr);
    end
    run_op(2'd0, 16'hFFFF, 16'hFFFF, 3'd5, 0);
    checks++;
    if (r_data !== 16'h0001) begin
      errors++;
      $display("FAIL mull_max: got %h, need 0001", r_data);
    end
  endtask

  task automatic test_div();
    run_op(2'd2, 16'd1000, 16'd7, 3'd1, 0);
    checks++;
    if (r_data !== 16'h008E || r_dbz !== 1'b0) begin
      errors++;
      $display("FAIL divu_1000_7: got %h dbz=%b, need 008e 0", r_data, r_dbz);
    end
    checks++;
    if (r_busy_len != 17) begin
      errors++;
      $display("FAIL busy_len: got %0d, need 17", r_busy_len);
    end
    run_op(2'd3, 16'd1000, 16'd7, 3'd1, 0);
    checks++;
    if (r_data !== 16'h0006) begin
      errors++;
      $display("FAIL remu_1000_7: got %h, need 0006", r_data);
    end
  endtask

  task automatic test_div_zero();
    run_op(2'd2, 16'h1234, 16'h0000, 3'd2, 0);
    checks++;
    if (r_data !== 16'hFFFF || r_dbz !== 1'b1 || r_addr !== 3'd2) begin
      errors++;
      $display("FAIL divu_zero: got %h dbz=%b addr=%0d, need ffff 1 2",
               r_data, r_dbz, r_addr);
    end
    run_op(2'd3, 16'h1234, 16'h0000, 3'd2, 0);
    checks++;
    if (r_data !== 16'h1234 || r_dbz !== 1'b1 || r_lat != 17) begin
      errors++;
      $display("FAIL remu_zero: got %h dbz=%b lat=%0d, need 1234 1 17",
               r_data, r_dbz, r_lat);
    end
  endtask

  task automatic test_reset_mid();
    int wes = 0;
    @(negedge clk);
    start = 1'b1; op = 2'd0; opA = 16'h00FF; opB = 16'h0002; dest = 3'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || we !== 1'b0 || dataR !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b we=%b data=%h, need 0 0 0",
               busy, we, dataR);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (we) wes++;
    end
    checks++;
    if (wes != 0) begin
      errors++;
      $display("FAIL reset_no_wb: got %0d we pulses, need 0", wes);
    end
    run_op(2'd0, 16'h00FF, 16'h0002, 3'd4, 0);
    checks++;
    if (r_data !== 16'h01FE || r_lat != 17) begin
      errors++;
      $display("FAIL after_reset: got %h lat=%0d, need 01fe 17", r_data, r_lat);
    end
  endtask

  task automatic test_start_while_busy();
    run_op(2'd2, 16'd5000, 16'd13, 3'd6, 5);
    checks++;
    if (r_data !== 16'd384 || r_addr !== 3'd6 || r_we_cnt != 1) begin
      errors++;
      $display("FAIL busy_ignore_run: got %0d addr=%0d pulses=%0d, need 384 6 1",
               r_data, r_addr, r_we_cnt);
    end
    run_op(2'd3, 16'd5000, 16'd13, 3'd7, 17);
    checks++;
    if (r_data !== 16'd8 || r_addr !== 3'd7 || r_we_cnt != 1) begin
      errors++;
      $display("FAIL busy_ignore_wb: got %0d addr=%0d pulses=%0d, need 8 7 1",
               r_data, r_addr, r_we_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  o;
      logic [15:0] a, b, exp_d;
      logic [2:0]  d;
      logic        exp_z;
      o = 2'($urandom); a = 16'($urandom); d = 3'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom >> ($urandom % 16));
      exp_d = model(o, a, b);
      exp_z = o[1] && (b == 0);
      run_op(o, a, b, d, 0);
      checks++;
      if (r_data !== exp_d || r_addr !== d || r_dbz !== exp_z
          || r_lat != 17 || r_we_cnt != 1 || r_spurious != 0) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: got %h/%0d/%b lat=%0d pulses=%0d, need %h/%0d/%b 17 1",
                 o, a, b, r_data, r_addr, r_dbz, r_lat, r_we_cnt,
                 exp_d, d, exp_z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mull_basic();
    test_mul_max();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
